// File: rtl/int_img_pkg.sv
// Shared types and helpers for the streaming integral-image engine.
// DEF_WIDTH / DEF_HEIGHT set the default frame geometry.
package int_img_pkg;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;

  localparam int PIX_W_DEF = 8;
  localparam int SUM_W_DEF = 32;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} int_img_state_t;
  typedef logic [SUM_W_DEF-1:0] sum_t;

  // Full 2*PIX_W product so 255*255 never truncates before widening.
  function automatic logic [2*PIX_W_DEF-1:0] sq_pix(input logic [PIX_W_DEF-1:0] p);
    logic [2*PIX_W_DEF-1:0] pe;
    pe = {{PIX_W_DEF{1'b0}}, p};
    return pe * pe;
  endfunction

endpackage

// File: rtl/int_img_stream_if.sv
// Pixel-in / integral-out handshake bundle plus frame control and status.
interface int_img_stream_if #(
  parameter int PIX_W        = 8,
  parameter int SUM_W        = 32,
  parameter int WIDTH_LIMIT  = 4,
  parameter int HEIGHT_LIMIT = 3
);
  localparam int RW = $clog2(HEIGHT_LIMIT);
  localparam int CW = $clog2(WIDTH_LIMIT);

  logic             start;
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             pix_ready;
  logic [SUM_W-1:0] ii_out;
  logic [SUM_W-1:0] ii_sq_out;
  logic [RW-1:0]    row_out;
  logic [CW-1:0]    col_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, pix_in, pix_valid, out_ready,
    input  pix_ready, ii_out, ii_sq_out, row_out, col_out, out_valid, busy, frame_done
  );

  modport slave (
    input  start, pix_in, pix_valid, out_ready,
    output pix_ready, ii_out, ii_sq_out, row_out, col_out, out_valid, busy, frame_done
  );
endinterface

// File: rtl/int_img_line_buf.sv
// One-row line buffer: combinational read, clocked write, shared address.
// A read and write to the same index in one cycle returns the old contents.
module int_img_line_buf #(
  parameter  int DEPTH = 4,
  parameter  int DW    = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/int_img_stream.sv
// Streaming integral image: one raster pixel in, ii/ii2 out one cycle later, one line buffer.
// INT_IMG_SQ_EN builds the squared-integral path; otherwise ii_sq_out is tied to 0.
module int_img_stream
  import int_img_pkg::*;
#(
  parameter int WIDTH_LIMIT  = DEF_WIDTH,
  parameter int HEIGHT_LIMIT = DEF_HEIGHT,
  parameter int PIX_W        = PIX_W_DEF,
  parameter int SUM_W        = SUM_W_DEF
) (
  input logic              clock,
  input logic              reset,
  int_img_stream_if.slave  bus
);

  localparam int RW = $clog2(HEIGHT_LIMIT);
  localparam int CW = $clog2(WIDTH_LIMIT);
  localparam logic [RW-1:0] R_LAST = RW'(HEIGHT_LIMIT - 1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH_LIMIT - 1);

  typedef logic [SUM_W-1:0] acc_t;

  int_img_state_t state_q, state_d;
  logic [RW-1:0]  row_q, row_d, orow_q, orow_d;
  logic [CW-1:0]  col_q, col_d, ocol_q, ocol_d;
  acc_t           rs_q, rs_d, ii_q, ii_d;
  acc_t           rs_sum, ii_new, lb_rd;
  logic           ovld_q, ovld_d, done_q, done_d;
  logic           pix_rdy, accept, last_pix;

  assign accept   = bus.pix_valid & pix_rdy;
  assign last_pix = (row_q == R_LAST) && (col_q == C_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (accept && last_pix) state_d = DRAIN;
      DRAIN:   if (ovld_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pix_rdy = (state_q == RUN) && (!ovld_q || bus.out_ready);
    done_d  = (state_q == DRAIN) && ovld_q && bus.out_ready;
  end

  // Row 0 masks the line buffer, so its contents never need clearing.
  always_comb begin
    rs_sum = ((col_q == '0) ? '0 : rs_q) + acc_t'(bus.pix_in);
    ii_new = rs_sum + ((row_q == '0) ? '0 : lb_rd);
    rs_d   = rs_q;
    row_d  = row_q;
    col_d  = col_q;
    ii_d   = ii_q;
    orow_d = orow_q;
    ocol_d = ocol_q;
    ovld_d = ovld_q;
    if (state_q == IDLE && bus.start) begin
      row_d = '0;
      col_d = '0;
    end
    if (accept) begin
      rs_d   = rs_sum;
      ii_d   = ii_new;
      orow_d = row_q;
      ocol_d = col_q;
      ovld_d = 1'b1;
      if (col_q == C_LAST) begin
        col_d = '0;
        row_d = (row_q == R_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (bus.out_ready) begin
      ovld_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_q  <= '0;
      col_q  <= '0;
      rs_q   <= '0;
      ii_q   <= '0;
      orow_q <= '0;
      ocol_q <= '0;
      ovld_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      rs_q   <= rs_d;
      ii_q   <= ii_d;
      orow_q <= orow_d;
      ocol_q <= ocol_d;
      ovld_q <= ovld_d;
      done_q <= done_d;
    end
  end

  int_img_line_buf #(.DEPTH(WIDTH_LIMIT), .DW(SUM_W)) u_lb (
    .clk     (clock),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (ii_new),
    .rdata_o (lb_rd)
  );

`ifdef INT_IMG_SQ_EN
  acc_t rs2_q, rs2_d, ii2_q, ii2_d, rs2_sum, ii2_new, lb2_rd;

  always_comb begin
    rs2_sum = ((col_q == '0) ? '0 : rs2_q) + acc_t'(sq_pix(bus.pix_in));
    ii2_new = rs2_sum + ((row_q == '0) ? '0 : lb2_rd);
    rs2_d   = accept ? rs2_sum : rs2_q;
    ii2_d   = accept ? ii2_new : ii2_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rs2_q <= '0;
      ii2_q <= '0;
    end else begin
      rs2_q <= rs2_d;
      ii2_q <= ii2_d;
    end
  end

  int_img_line_buf #(.DEPTH(WIDTH_LIMIT), .DW(SUM_W)) u_lb2 (
    .clk     (clock),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (ii2_new),
    .rdata_o (lb2_rd)
  );

  assign bus.ii_sq_out = ii2_q;
`else
  assign bus.ii_sq_out = '0;
`endif

  assign bus.pix_ready  = pix_rdy;
  assign bus.ii_out     = ii_q;
  assign bus.row_out    = orow_q;
  assign bus.col_out    = ocol_q;
  assign bus.out_valid  = ovld_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_int_img_stream.sv
// Directed bench for int_img_stream on a 4x3 frame with 16-bit sums (exercises wrap).
module tb_int_img_stream;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;
  localparam int SW   = 16;
`ifdef INT_IMG_SQ_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int_img_stream_if #(.PIX_W(8), .SUM_W(SW), .WIDTH_LIMIT(W), .HEIGHT_LIMIT(H)) bus ();

  int_img_stream #(.WIDTH_LIMIT(W), .HEIGHT_LIMIT(H), .PIX_W(8), .SUM_W(SW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [7:0] pix(input int pat, input int k);
    logic [31:0] v;
    case (pat)
      0:       v = 1;
      1:       v = k;
      2:       v = 255;
      default: v = k * 37 + 11;
    endcase
    return v[7:0];
  endfunction

  logic [SW-1:0] m_ii  [NPIX];
  logic [SW-1:0] m_ii2 [NPIX];
  logic [SW-1:0] got_ii  [NPIX];
  logic [SW-1:0] got_ii2 [NPIX];

  // Brute-force rectangle sums, independent of the streaming recurrence.
  task automatic build_model(input int pat);
    for (int k = 0; k < NPIX; k++) begin
      logic [SW-1:0] s, s2;
      logic [31:0]   p;
      s = '0;
      s2 = '0;
      for (int rr = 0; rr <= k / W; rr++)
        for (int cc = 0; cc <= k % W; cc++) begin
          p  = {24'd0, pix(pat, rr * W + cc)};
          s  = s + p[SW-1:0];
          p  = p * p;
          s2 = s2 + p[SW-1:0];
        end
      m_ii[k]  = s;
      m_ii2[k] = SQ ? s2 : '0;
    end
  endtask

  task automatic run_frame(input int pat, input int stall_k, input int stall_n, input bit mid_start);
    int  sent, recv, cyc, used;
    bit  stalling;
    build_model(pat);
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    sent = 0; recv = 0; cyc = 0; used = 0;
    while (recv < NPIX && cyc < 100) begin
      stalling      = (recv == stall_k) && (used < stall_n);
      bus.out_ready = !stalling;
      bus.pix_valid = (sent < NPIX);
      bus.pix_in    = pix(pat, sent);
      bus.start     = mid_start && (cyc == 5);
      #1;
      if (stalling) begin
        used++;
        chk("stall_pix_ready", bus.pix_ready, 0);
        chk("stall_out_valid", bus.out_valid, 1);
        chk("stall_hold_ii", bus.ii_out, m_ii[recv]);
        chk("stall_hold_col", bus.col_out, recv % W);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("out_row", bus.row_out, recv / W);
        chk("out_col", bus.col_out, recv % W);
        chk("out_ii", bus.ii_out, m_ii[recv]);
        chk("out_ii2", bus.ii_sq_out, m_ii2[recv]);
        got_ii[recv]  = bus.ii_out;
        got_ii2[recv] = bus.ii_sq_out;
        recv++;
      end
      if (bus.pix_valid && bus.pix_ready) sent++;
      @(negedge clock);
      cyc++;
    end
    bus.pix_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.start     = 1'b0;
    chk("frame_cycles", cyc, NPIX + 1 + stall_n);
    #1;
    chk("frame_done_pulse", bus.frame_done, 1);
    chk("busy_after_frame", bus.busy, 0);
    chk("out_valid_after_frame", bus.out_valid, 0);
    @(negedge clock);
    #1;
    chk("frame_done_clear", bus.frame_done, 0);
  endtask

  typedef struct {
    string name;
    int    pat;
    int    stall_k;
    int    stall_n;
    bit    mid_start;
    int    r;
    int    c;
    int    exp_ii;
    int    exp_ii2;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{"ones_0_0",      0, -1, 0, 1'b0, 0, 0,    1,     1};
    tbl[1]  = '{"ones_1_2",      0, -1, 0, 1'b0, 1, 2,    6,     6};
    tbl[2]  = '{"ones_2_3",      0, -1, 0, 1'b0, 2, 3,   12,    12};
    tbl[3]  = '{"ramp_1_1",      1, -1, 0, 1'b0, 1, 1,   10,    42};
    tbl[4]  = '{"ramp_0_3",      1, -1, 0, 1'b0, 0, 3,    6,    14};
    tbl[5]  = '{"ramp_2_3",      1, -1, 0, 1'b0, 2, 3,   66,   506};
    tbl[6]  = '{"ramp_stall_2_3",1,  6, 3, 1'b0, 2, 3,   66,   506};
    tbl[7]  = '{"sat_0_1_wrap",  2, -1, 0, 1'b0, 0, 1,  510, 64514};
    tbl[8]  = '{"sat_2_3_wrap",  2, -1, 0, 1'b0, 2, 3, 3060, 59404};
    tbl[9]  = '{"ones_midstart", 0, -1, 0, 1'b1, 2, 3,   12,    12};
    tbl[10] = '{"ramp_1_2",      1, -1, 0, 1'b0, 1, 2,   18,    82};

    bus.start = 1'b0;
    bus.pix_in = '0;
    bus.pix_valid = 1'b0;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_pix_ready", bus.pix_ready, 0);
    chk("rst_ii", bus.ii_out, 0);
    chk("rst_ii2", bus.ii_sq_out, 0);
    chk("rst_row_col", {bus.row_out, bus.col_out}, 0);
    reset = 1'b0;

    // Pixels offered while idle must be refused and produce nothing.
    bus.pix_valid = 1'b1;
    bus.pix_in = 8'd9;
    repeat (3) begin
      @(negedge clock);
      #1;
      chk("idle_pix_ready", bus.pix_ready, 0);
      chk("idle_out_valid", bus.out_valid, 0);
    end
    bus.pix_valid = 1'b0;

    // Reset mid-frame after (1,1) has been produced.
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.pix_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.pix_in = pix(1, k);
      @(negedge clock);
    end
    #1;
    chk("pre_reset_valid", bus.out_valid, 1);
    chk("pre_reset_ii_1_1", bus.ii_out, 10);
    chk("pre_reset_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_frame_done", bus.frame_done, 0);
    bus.pix_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_frame(tbl[i].pat, tbl[i].stall_k, tbl[i].stall_n, tbl[i].mid_start);
      chk({tbl[i].name, "_ii"}, got_ii[tbl[i].r * W + tbl[i].c], tbl[i].exp_ii);
      chk({tbl[i].name, "_ii2"}, got_ii2[tbl[i].r * W + tbl[i].c], SQ ? tbl[i].exp_ii2 : 0);
    end

    // A frame with no arithmetic structure, checked only against the model.
    run_frame(3, 2, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
